// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_RDATA     = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  function automatic logic f3_supported(input logic [2:0] funct3);
    return (funct3 == F3_ADD) || (funct3 == F3_OR) || (funct3 == F3_AND);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction fields onto the simple_alu control code.
module alu_decoder
  import ctrl_pkg::*;
(
  input  aluop_e     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [1:0] alu_control
);

  // NOTE: assign a default before the case so every path drives the output and no latch is inferred.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          F3_ADD:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_control = ALU_AND;
          F3_OR:   alu_control = ALU_OR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute and drives the
// datapath enables, mux selects and ALU control.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter state_e RESET_STATE = S_FETCH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUControl,
  output logic       illegal
);

  state_e state_q, state_d;
  state_e out_state;
  aluop_e alu_op;
  logic   pc_update;
  logic   branch;

  // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = f3_supported(funct3) ? S_EXECR : S_TRAP;
          OP_I:         state_d = f3_supported(funct3) ? S_EXECI : S_TRAP;
          OP_BEQ:       state_d = (funct3 == F3_ADD) ? S_BEQ : S_TRAP;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL:               state_d = S_ALUWB;
      S_ALUWB, S_MEMWB, S_MEMWRITE, S_BEQ:   state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_FETCH;
    endcase
  end

  // A cycle with reset asserted already shows fetch controls, so nothing half-done is written back.
  assign out_state = reset ? S_FETCH : state_q;

  always_comb begin
    AdrSrc    = ADR_PC;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    RegWrite  = 1'b0;
    illegal   = 1'b0;
    alu_op    = ALUOP_ADD;
    pc_update = 1'b0;
    branch    = 1'b0;
    case (out_state)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        pc_update = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD:  AdrSrc = ADR_RESULT;
      S_MEMWRITE: begin
        AdrSrc   = ADR_RESULT;
        MemWrite = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_RD2;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_TRAP:  illegal = 1'b1;
      default: ;
    endcase
  end

  assign PCWrite = pc_update | (branch & zero);
  assign ImmSrc  = imm_src_of(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction's expected per-cycle
// control word comes from a table indexed by instruction class and cycle number.
module tb_multicycle_ctrl;

  typedef enum int {K_LW, K_SW, K_R, K_I, K_BEQ, K_JAL, K_BAD} kind_e;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Packing order: PCWrite AdrSrc MemWrite IRWrite ResultSrc ALUSrcA ALUSrcB RegWrite ImmSrc ALUControl illegal
  logic [15:0] got;
  assign got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                RegWrite, ImmSrc, ALUControl, illegal};

  task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (PCW AS MW IRW RS SA SB RW IMM AC ILL)",
               tag, actual, expected);
    end
  endtask

  function automatic kind_e classify(input logic [6:0] o, input logic [2:0] f3);
    logic f3_ok;
    f3_ok = (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
    if (o == 7'b0000011) return K_LW;
    if (o == 7'b0100011) return K_SW;
    if (o == 7'b0110011) return f3_ok ? K_R : K_BAD;
    if (o == 7'b0010011) return f3_ok ? K_I : K_BAD;
    if (o == 7'b1100011) return (f3 == 3'b000) ? K_BEQ : K_BAD;
    if (o == 7'b1101111) return K_JAL;
    return K_BAD;
  endfunction

  function automatic int length_of(input kind_e k);
    case (k)
      K_LW:    return 5;
      K_BEQ:   return 3;
      default: return 4;
    endcase
  endfunction

  // Expected control word for cycle 'step' (0 = fetch) of an instruction.
  function automatic logic [15:0] model(input kind_e k, input int step, input logic [6:0] o,
                                        input logic [2:0] f3, input logic f7, input logic z);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm, ac = 0;
    case (o)
      7'b0100011: imm = 2'd1;
      7'b1100011: imm = 2'd2;
      7'b1101111: imm = 2'd3;
      default:    imm = 2'd0;
    endcase
    if (step == 0) begin
      irw = 1; pcw = 1; sb = 2; rs = 2;
    end else if (step == 1) begin
      sa = 1; sb = 1;
    end else begin
      case (k)
        K_LW, K_SW: begin
          if (step == 2) begin sa = 2; sb = 1; end
          else if (step == 3 && k == K_SW) begin adr = 1; mw = 1; end
          else if (step == 3) adr = 1;
          else begin rs = 1; rw = 1; end
        end
        K_R, K_I: begin
          if (step == 2) begin
            sa = 2;
            sb = (k == K_I) ? 2'd1 : 2'd0;
            if (f3 == 3'b111)      ac = 2;
            else if (f3 == 3'b110) ac = 3;
            else                   ac = (k == K_R && f7) ? 2'd1 : 2'd0;
          end else rw = 1;
        end
        K_BEQ: begin sa = 2; ac = 1; pcw = z; end
        K_JAL: begin
          if (step == 2) begin sa = 1; sb = 2; pcw = 1; end
          else rw = 1;
        end
        default: ill = 1;
      endcase
    end
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, ac, ill};
  endfunction

  // Called at posedge+1; holds reset for one edge while checking the reset-cycle outputs.
  task automatic reset_cycle(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    reset = 1'b1;
    zero  = 1'($urandom);
    #4 check("reset_cycle", got, model(K_LW, 0, o, f3, f7, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Runs one instruction from its fetch cycle; abort_at >= 0 asserts reset at that cycle.
  // zval < 0 randomizes the zero flag each cycle.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input int abort_at, input int trap_cycles, input int zval);
    kind_e k;
    int    len;
    logic  z;
    k   = classify(o, f3);
    len = (k == K_BAD) ? 2 + trap_cycles : length_of(k);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int step = 0; step < len; step++) begin
      if (step == abort_at) begin
        reset_cycle(o, f3, f7);
        return;
      end
      z    = (zval < 0) ? 1'($urandom) : 1'(zval);
      zero = z;
      #4 check($sformatf("%s op=%b f3=%b f7=%b step%0d", k.name(), o, f3, f7, step),
               got, model(k, step, o, f3, f7, z));
      @(posedge clk); #1;
    end
    if (k == K_BAD) reset_cycle(o, f3, f7);
  endtask

  initial begin
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    int         sel, ab;
    logic [6:0] legal_ops [6];
    legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

    reset = 1'b1; op = 7'b1111111; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    reset_cycle(7'b0110011, 3'b000, 1'b0);

    run_instr(7'b0000011, 3'b010, 1'b0, -1, 0, -1);   // lw
    run_instr(7'b0100011, 3'b010, 1'b0,  2, 0, -1);   // sw, reset in MEMADR
    run_instr(7'b0100011, 3'b010, 1'b0, -1, 0, -1);   // sw full
    run_instr(7'b0110011, 3'b000, 1'b1, -1, 0, -1);   // sub
    run_instr(7'b0110011, 3'b110, 1'b0, -1, 0, -1);   // or
    run_instr(7'b0110011, 3'b111, 1'b1, -1, 0, -1);   // and
    run_instr(7'b0010011, 3'b000, 1'b1, -1, 0, -1);   // addi, never sub
    run_instr(7'b1100011, 3'b000, 1'b0, -1, 0,  1);   // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, -1, 0,  0);   // beq not taken
    run_instr(7'b1101111, 3'b011, 1'b1, -1, 0, -1);   // jal
    run_instr(7'b1111111, 3'b000, 1'b0, -1, 20, -1);  // trap for 20 cycles
    run_instr(7'b0110011, 3'b001, 1'b0, -1, 3, -1);   // unsupported funct3

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 7));
      f3  = 3'($urandom);
      f7  = 1'($urandom);
      if (sel < 6) begin
        o = legal_ops[sel];
        if (sel >= 2 && sel <= 3) f3 = (f3[0]) ? 3'b000 : {2'b11, f3[1]};
        if (sel == 4) f3 = 3'b000;
      end else begin
        o = 7'($urandom);
        if (sel == 7) o = legal_ops[$urandom_range(2, 4)];
      end
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(o, f3, f7, ab, int'($urandom_range(1, 6)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
